// File: rtl/bram_uart_dumper_pkg.sv
// Shared definitions for the block-RAM UART dumper.
//   UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   calc_divisor()  : clock cycles per UART bit, rounded to nearest
//   state_t         : dumper sequencing states
package bram_uart_dumper_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;

  // Rounded division, so 12 MHz / 115200 baud gives 104 rather than truncating.
  function automatic int unsigned calc_divisor(input int unsigned clock_hz,
                                               input int unsigned baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND_HI,
    SEND_LO,
    ADVANCE
  } state_t;

endpackage

// File: rtl/bram_uart_dumper_tx.sv
// uart_tx_byte: 8N1 UART serializer, reusable by other UART blocks.
//   CLK        : clock
//   reset      : synchronous, active-high; forces TX high and drops any frame
//   load       : accepted only while ready is high
//   tx_byte    : byte captured on an accepted load
//   ready      : high while no frame is in flight
//   TX         : serial line, idles high, start bit begins the cycle after load
//   frame_done : one-cycle pulse during the last cycle of the stop bit
module uart_tx_byte
  import bram_uart_dumper_pkg::*;
#(
  parameter int unsigned DIVISOR = 104
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic       TX,
  output logic       frame_done
);

  localparam int unsigned     DIV_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [3:0]      LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic             active_q, active_d;
  logic             tx_q, tx_d;
  logic [8:0]       shift_q, shift_d;   // data bits still to send, stop bit on top
  logic [3:0]       bit_q, bit_d;       // index of the bit currently on the line
  logic [DIV_W-1:0] div_q, div_d;
  logic             bit_end;

  assign bit_end    = active_q && (div_q == DIV_LAST);
  assign ready      = ~active_q;
  assign TX         = tx_q;
  // Combinational so the caller can load the next byte in the very next cycle.
  assign frame_done = bit_end && (bit_q == LAST_BIT);

  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = div_q;
    if (!active_q) begin
      if (load) begin
        active_d = 1'b1;
        tx_d     = 1'b0;
        shift_d  = {1'b1, tx_byte};
        bit_d    = '0;
        div_d    = '0;
      end
    end else if (bit_end) begin
      div_d = '0;
      if (bit_q == LAST_BIT) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      shift_q  <= '1;
      bit_q    <= '0;
      div_q    <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
    end
  end

endmodule

// File: rtl/bram_uart_dumper.sv
// bram_uart_dumper: reads words FIRST_ADDRESS..LAST_ADDRESS from a 16-bit
// block RAM read port and sends each word high byte first as 8N1 frames.
//   CLK          : clock (also the RAM read clock outside this block)
//   reset        : synchronous, active-high
//   start        : one-cycle pulse, ignored unless idle
//   read_address : RAM read address
//   read_enable  : RAM read enable, data returns the following cycle
//   read_data    : RAM read data
//   TX           : UART line, idles high
//   busy         : high while a dump is in progress
//   done         : one-cycle pulse when the last word has been sent
module bram_uart_dumper
  import bram_uart_dumper_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 12000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned ADDRESS_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned FIRST_ADDRESS   = 0,
  parameter int unsigned LAST_ADDRESS    = 255
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     read_enable,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     TX,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_ADDR = ADDRESS_WIDTH'(FIRST_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(LAST_ADDRESS);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;

  logic       ser_load;
  logic [7:0] ser_byte;
  logic       ser_ready;
  logic       ser_frame_done;

  uart_tx_byte #(
    .DIVISOR(DIVISOR)
  ) u_tx (
    .CLK       (CLK),
    .reset     (reset),
    .load      (ser_load),
    .tx_byte   (ser_byte),
    .ready     (ser_ready),
    .TX        (TX),
    .frame_done(ser_frame_done)
  );

  assign read_address = addr_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    ser_load    = 1'b0;
    ser_byte    = word_q[15:8];
    read_enable = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = FIRST_ADDR;
        end
      end
      READ: begin
        read_enable = 1'b1;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        word_d  = read_data;
        state_d = SEND_HI;
      end
      // ready drops the cycle after a load, so holding load on ready
      // issues exactly one load per byte.
      SEND_HI: begin
        ser_byte = word_q[15:8];
        ser_load = ser_ready;
        if (ser_frame_done) state_d = SEND_LO;
      end
      SEND_LO: begin
        ser_byte = word_q[7:0];
        ser_load = ser_ready;
        if (ser_frame_done) state_d = ADVANCE;
      end
      // Compare before incrementing so a range ending at the top address
      // terminates instead of wrapping to zero.
      ADVANCE: begin
        if (addr_q == LAST_ADDR) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= FIRST_ADDR;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

endmodule
